sevenseg_scan_driver: RTL and testbench
=======================================

Name: sevenseg_scan_driver

Overview:
- Downstream consumer of the clock divider's slow square-wave output. It drives a time-multiplexed common-anode 7-segment display.
- Samples the divided clock in the system Clock domain and converts each rising edge into a one-cycle scan tick.
- Each scan tick advances the active digit. The block decodes that digit's 4-bit hex nibble into segment drives.
- Display value is snapshotted once per full scan frame, so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SEG_ACTIVE_LOW, 1, 1 = segment and DP outputs are driven low to light.
- AN_ACTIVE_LOW, 1, 1 = anode enables are driven low to select a digit.

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-low reset (0 = reset).
- ScanClock  in  1  divided clock from clock divider; not assumed phase-related to Clock.
- Enable  in  1  1 = scanning active; 0 = display blanked.
- Value  in  4*NUM_DIGITS  hex digits; digit 0 = bits [3:0] = rightmost.
- DpIn  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- Anodes  out  NUM_DIGITS  digit select; one-hot active when Enable=1.
- Segments  out  7  segment drive, bit order {g,f,e,d,c,b,a}, a = bit 0.
- DecimalPoint  out  1  DP drive for the active digit.
- DigitIndex  out  clog2(NUM_DIGITS)  index of the active digit.

Behaviour:
- Synchroniser and tick:
  - ScanClock passes through a 2-flop synchroniser, then a third flop holds the previous value.
  - tick = sync2 & ~sync3, high for exactly one Clock cycle per ScanClock rising edge.
  - Falling edges are ignored.
- Latency: Anodes, Segments, DecimalPoint and DigitIndex are registered. They change on the Clock edge at which tick is sampled high, i.e. the 3rd Clock edge after ScanClock's rise is first sampled.
- Digit counter:
  - On tick with Enable=1, DigitIndex advances to (DigitIndex+1) mod NUM_DIGITS, so NUM_DIGITS-1 wraps to 0.
  - With Enable=0, the index holds.
- Snapshot:
  - Shadow register loads Value and DpIn on the tick that moves the index to 0.
  - It also loads on the first tick after reset.
  - Value changes between snapshots have no effect on the display.
- Decode: standard hex font, logical active-high form {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - Output is inverted when SEG_ACTIVE_LOW=1.
- Anodes: the active digit is asserted, all others deasserted. Polarity follows AN_ACTIVE_LOW.
- Enable=0: on the next Clock edge, all anodes, segments and DP go to their inactive levels. Counter and shadow hold. Scanning resumes on the next tick after Enable returns to 1.
- Reset (Reset=0 sampled on a Clock edge):
  - DigitIndex=0, shadow=0, synchroniser flops=0.
  - Anodes, Segments and DecimalPoint all at inactive levels.
  - A reset mid-frame discards the current frame.
  - The first tick after reset loads the snapshot and lights digit 0.
- Simultaneous tick and Enable falling: blanking wins and the index does not advance.

Optional Feature:
- Macro: SEVSEG_LEADING_ZERO_BLANK_EN.
- Defined: a digit whose snapshotted nibble is 0 is blanked (segments inactive, anode still driven) when all higher-index nibbles are also 0.
  - Digit 0 is never blanked.
  - The DP still follows DpIn.
- Undefined: every digit is always decoded; no comparison logic is present.

Decomposition:
- Package sevenseg_pkg:
  - 16-entry segment font constants.
  - Segment bit-position constants (SEG_A..SEG_G).
  - Default NUM_DIGITS.
- One sub-module, hex_to_sevenseg: combinational nibble to active-high 7-bit pattern. Polarity inversion stays in the parent.

Test Plan:
- Reset check: hold Reset=0 for 3 cycles, toggling ScanClock -> Anodes=4'b1111, Segments=7'b1111111, DecimalPoint=1, DigitIndex=0 (active-low defaults).
- Scan order: Value=16'h1234, DpIn=4'b0100, Enable=1, 8 ScanClock rises.
  - Digits cycle 0,1,2,3,0,...
  - Anodes = 1110, 1101, 1011, 0111.
  - Segments (active-low) = ~7'b1100110 (4), ~1001111 (3), ~1011011 (2), ~0000110 (1).
  - DP lit only when DigitIndex=2.
  - Each change lands exactly 3 Clock cycles after the ScanClock rise.
- Anti-tearing: change Value 16'h1234 to 16'hABCD while DigitIndex=1 -> digits 2 and 3 still show 2 and 1; A/B/C/D appear only after the wrap to digit 0.
- Enable gating: drop Enable for 5 ticks at DigitIndex=2 -> outputs inactive next cycle, index stays 2; on re-enable, the next tick shows digit 3.
- Parameter wrap: NUM_DIGITS=3, Value=12'hF0E -> index sequence 0,1,2,0; digit 1 shows 0 (macro off).
- Macro on: SEVSEG_LEADING_ZERO_BLANK_EN, Value=16'h0050 -> digits 3 and 2 blanked, digit 1 shows 5, digit 0 shows 0.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// hex font (active-high {g..a}), segment bit positions, default digit count.
package sevenseg_pkg;

  localparam int DEF_NUM_DIGITS = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [15:0][6:0] SEG_FONT = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/sevenseg_scan_driver_hex_to_sevenseg.sv
// Combinational hex nibble to active-high segment pattern {g..a}.
// Output polarity is applied by the parent.
module hex_to_sevenseg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with per-frame snapshot.
// Optional: SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IW            = $clog2(NUM_DIGITS)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    ScanClock,
  input  logic                    Enable,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  output logic [NUM_DIGITS-1:0]   Anodes,
  output logic [6:0]              Segments,
  output logic                    DecimalPoint,
  output logic [IW-1:0]           DigitIndex
);

  logic sync1_q, sync2_q, sync3_q;
  logic tick, adv;

  logic                    armed_q, armed_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;

  logic [3:0]              nib;
  logic [6:0]              seg_raw;
  logic [6:0]              seg_on;
  logic                    blank;
  logic                    dp_lit;
  logic [NUM_DIGITS-1:0]   an_on;

  assign tick = sync2_q & ~sync3_q;
  assign adv  = tick & Enable;

  // armed_q clear means no snapshot yet: the first tick loads and shows digit 0
  always_comb begin
    armed_d = armed_q;
    idx_d   = idx_q;
    val_d   = val_q;
    dp_d    = dp_q;
    if (adv) begin
      armed_d = 1'b1;
      if (!armed_q) begin
        idx_d = '0;
        val_d = Value;
        dp_d  = DpIn;
      end else begin
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          idx_d = '0;
          val_d = Value;
          dp_d  = DpIn;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  assign nib    = 4'(val_d >> {idx_d, 2'b00});
  assign dp_lit = dp_d[idx_d];
  assign an_on  = NUM_DIGITS'(1) << idx_d;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  assign blank = (idx_d != '0) && ((val_d >> {idx_d, 2'b00}) == '0);
`else
  assign blank = 1'b0;
`endif

  hex_to_sevenseg u_font (
    .nibble_i (nib),
    .seg_o    (seg_raw)
  );

  assign seg_on = blank ? 7'b0 : seg_raw;

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dpo_d = dpo_q;
    if (!Enable) begin
      an_d  = {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_d = {7{SEG_ACTIVE_LOW}};
      dpo_d = SEG_ACTIVE_LOW;
    end else if (adv) begin
      an_d  = an_on ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_d = seg_on ^ {7{SEG_ACTIVE_LOW}};
      dpo_d = dp_lit ^ SEG_ACTIVE_LOW;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      armed_q <= 1'b0;
      idx_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      an_q    <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_q   <= {7{SEG_ACTIVE_LOW}};
      dpo_q   <= SEG_ACTIVE_LOW;
    end else begin
      sync1_q <= ScanClock;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      armed_q <= armed_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
    end
  end

  assign Anodes       = an_q;
  assign Segments     = seg_q;
  assign DecimalPoint = dpo_q;
  assign DigitIndex   = idx_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed self-checking bench for sevenseg_scan_driver (4- and 3-digit).
// Define SEVSEG_LEADING_ZERO_BLANK_EN to expect leading-zero blanking.
module tb_sevenseg_scan_driver;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ScanClock;
  logic        Enable;
  logic [15:0] Value;
  logic [3:0]  DpIn;
  logic [3:0]  Anodes;
  logic [6:0]  Segments;
  logic        DecimalPoint;
  logic [1:0]  DigitIndex;

  logic [11:0] Value3;
  logic [2:0]  DpIn3;
  logic [2:0]  Anodes3;
  logic [6:0]  Segments3;
  logic        DecimalPoint3;
  logic [1:0]  DigitIndex3;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  sevenseg_scan_driver u_dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .ScanClock    (ScanClock),
    .Enable       (Enable),
    .Value        (Value),
    .DpIn         (DpIn),
    .Anodes       (Anodes),
    .Segments     (Segments),
    .DecimalPoint (DecimalPoint),
    .DigitIndex   (DigitIndex)
  );

  sevenseg_scan_driver #(.NUM_DIGITS(3)) u_dut3 (
    .Clock        (Clock),
    .Reset        (Reset),
    .ScanClock    (ScanClock),
    .Enable       (Enable),
    .Value        (Value3),
    .DpIn         (DpIn3),
    .Anodes       (Anodes3),
    .Segments     (Segments3),
    .DecimalPoint (DecimalPoint3),
    .DigitIndex   (DigitIndex3)
  );

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'b0111111;
      4'h1: font = 7'b0000110;
      4'h2: font = 7'b1011011;
      4'h3: font = 7'b1001111;
      4'h4: font = 7'b1100110;
      4'h5: font = 7'b1101101;
      4'h6: font = 7'b1111101;
      4'h7: font = 7'b0000111;
      4'h8: font = 7'b1111111;
      4'h9: font = 7'b1101111;
      4'hA: font = 7'b1110111;
      4'hB: font = 7'b1111100;
      4'hC: font = 7'b0111001;
      4'hD: font = 7'b1011110;
      4'hE: font = 7'b1111001;
      default: font = 7'b1110001;
    endcase
  endfunction

  function automatic logic [3:0] an4(input int d);
    logic [3:0] one;
    one = 4'b0001;
    an4 = ~(one << d);
  endfunction

  task automatic pulse();
    @(negedge Clock);
    ScanClock = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    #1;
  endtask

  task automatic rise();
    pulse();
    @(posedge Clock);
    #1;
  endtask

  task automatic fall();
    @(negedge Clock);
    ScanClock = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Enable = 1'b1;
    Value = 16'h0000;
    DpIn = 4'b0000;
    Value3 = 12'hF0E;
    DpIn3 = 3'b000;
    ScanClock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      ScanClock = ~ScanClock;
    end
    @(posedge Clock);
    #1;
    tests++;
    if (Anodes !== 4'b1111) begin
      fails++;
      $display("FAIL reset_an got %b want 1111", Anodes);
    end
    tests++;
    if (Segments !== 7'h7F) begin
      fails++;
      $display("FAIL reset_seg got %b want 1111111", Segments);
    end
    tests++;
    if (DecimalPoint !== 1'b1) begin
      fails++;
      $display("FAIL reset_dp got %b want 1", DecimalPoint);
    end
    tests++;
    if (DigitIndex !== 2'd0) begin
      fails++;
      $display("FAIL reset_idx got %0d want 0", DigitIndex);
    end
    tests++;
    if (Anodes3 !== 3'b111) begin
      fails++;
      $display("FAIL reset_an3 got %b want 111", Anodes3);
    end
    @(negedge Clock);
    ScanClock = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_scan_order();
    logic [3:0] prev_an;
    logic [3:0] nib;
    logic [15:0] v;
    int d;
    Value = 16'h1234;
    DpIn = 4'b0100;
    v = 16'h1234;
    prev_an = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      d = k % 4;
      nib = 4'(v >> (4 * d));
      pulse();
      tests++;
      if (Anodes !== prev_an) begin
        fails++;
        $display("FAIL scan_early[%0d] got %b want %b", k, Anodes, prev_an);
      end
      @(posedge Clock);
      #1;
      tests++;
      if (DigitIndex !== 2'(d)) begin
        fails++;
        $display("FAIL scan_idx[%0d] got %0d want %0d", k, DigitIndex, d);
      end
      tests++;
      if (Anodes !== an4(d)) begin
        fails++;
        $display("FAIL scan_an[%0d] got %b want %b", k, Anodes, an4(d));
      end
      tests++;
      if (Segments !== ~font(nib)) begin
        fails++;
        $display("FAIL scan_seg[%0d] got %b want %b", k, Segments, ~font(nib));
      end
      tests++;
      if (DecimalPoint !== (d != 2)) begin
        fails++;
        $display("FAIL scan_dp[%0d] got %b want %b", k, DecimalPoint, d != 2);
      end
      prev_an = an4(d);
      fall();
    end
  endtask

  task automatic test_anti_tear();
    logic [3:0] exp_n [6];
    int exp_d [6];
    exp_n = '{4'h2, 4'h1, 4'hD, 4'hC, 4'hB, 4'hA};
    exp_d = '{2, 3, 0, 1, 2, 3};
    rise();
    fall();
    rise();
    fall();
    tests++;
    if (DigitIndex !== 2'd1) begin
      fails++;
      $display("FAIL tear_pre_idx got %0d want 1", DigitIndex);
    end
    Value = 16'hABCD;
    for (int k = 0; k < 6; k++) begin
      rise();
      tests++;
      if (DigitIndex !== 2'(exp_d[k])) begin
        fails++;
        $display("FAIL tear_idx[%0d] got %0d want %0d", k, DigitIndex, exp_d[k]);
      end
      tests++;
      if (Segments !== ~font(exp_n[k])) begin
        fails++;
        $display("FAIL tear_seg[%0d] got %b want %b", k, Segments, ~font(exp_n[k]));
      end
      fall();
    end
  endtask

  task automatic test_enable();
    rise();
    fall();
    rise();
    fall();
    rise();
    fall();
    tests++;
    if (DigitIndex !== 2'd2 || Segments !== ~font(4'hB)) begin
      fails++;
      $display("FAIL en_pre got idx %0d seg %b want idx 2 seg %b", DigitIndex, Segments, ~font(4'hB));
    end
    @(negedge Clock);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    tests++;
    if (Anodes !== 4'b1111 || Segments !== 7'h7F || DecimalPoint !== 1'b1) begin
      fails++;
      $display("FAIL en_blank got an %b seg %b dp %b want 1111 1111111 1", Anodes, Segments, DecimalPoint);
    end
    for (int k = 0; k < 5; k++) begin
      rise();
      tests++;
      if (DigitIndex !== 2'd2 || Anodes !== 4'b1111) begin
        fails++;
        $display("FAIL en_hold[%0d] got idx %0d an %b want idx 2 an 1111", k, DigitIndex, Anodes);
      end
      fall();
    end
    Enable = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    tests++;
    if (Anodes !== 4'b1111) begin
      fails++;
      $display("FAIL en_wait got an %b want 1111", Anodes);
    end
    rise();
    tests++;
    if (DigitIndex !== 2'd3 || Anodes !== 4'b0111 || Segments !== ~font(4'hA) || DecimalPoint !== 1'b1) begin
      fails++;
      $display("FAIL en_resume got idx %0d an %b seg %b dp %b want 3 0111 %b 1", DigitIndex, Anodes, Segments, DecimalPoint, ~font(4'hA));
    end
    fall();
  endtask

  task automatic test_tick_enable_fall();
    @(negedge Clock);
    ScanClock = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    tests++;
    if (DigitIndex !== 2'd3 || Anodes !== 4'b1111) begin
      fails++;
      $display("FAIL tick_en_fall got idx %0d an %b want 3 1111", DigitIndex, Anodes);
    end
    fall();
    Enable = 1'b1;
    rise();
    tests++;
    if (DigitIndex !== 2'd0 || Segments !== ~font(4'hD)) begin
      fails++;
      $display("FAIL tick_en_next got idx %0d seg %b want 0 %b", DigitIndex, Segments, ~font(4'hD));
    end
    fall();
  endtask

  task automatic test_param_wrap();
    int exp3_d [4];
    logic [3:0] exp3_n [4];
    exp3_d = '{0, 1, 2, 0};
    exp3_n = '{4'hE, 4'h0, 4'hF, 4'hE};
    rise();
    fall();
    Value = 16'h9876;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    for (int k = 0; k < 4; k++) begin
      rise();
      tests++;
      if (DigitIndex3 !== 2'(exp3_d[k])) begin
        fails++;
        $display("FAIL wrap3_idx[%0d] got %0d want %0d", k, DigitIndex3, exp3_d[k]);
      end
      tests++;
      if (Segments3 !== ~font(exp3_n[k])) begin
        fails++;
        $display("FAIL wrap3_seg[%0d] got %b want %b", k, Segments3, ~font(exp3_n[k]));
      end
      if (k == 0) begin
        tests++;
        if (DigitIndex !== 2'd0 || Anodes !== 4'b1110 || Segments !== ~font(4'h6)) begin
          fails++;
          $display("FAIL reset_frame got idx %0d an %b seg %b want 0 1110 %b", DigitIndex, Anodes, Segments, ~font(4'h6));
        end
      end
      fall();
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] exp_s [4];
    logic [6:0] hi;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    hi = 7'h7F;
`else
    hi = ~font(4'h0);
`endif
    exp_s = '{~font(4'h0), ~font(4'h5), hi, hi};
    Value = 16'h0050;
    DpIn = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      rise();
      tests++;
      if (Anodes !== an4(k) || Segments !== exp_s[k]) begin
        fails++;
        $display("FAIL lz[%0d] got an %b seg %b want %b %b", k, Anodes, Segments, an4(k), exp_s[k]);
      end
      tests++;
      if (DecimalPoint !== (k != 0)) begin
        fails++;
        $display("FAIL lz_dp[%0d] got %b want %b", k, DecimalPoint, k != 0);
      end
      fall();
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_anti_tear();
    test_enable();
    test_tick_enable_fall();
    test_param_wrap();
    test_leading_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
